// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// DramArbiter : shares the single-port data RAM between the CPU MEM stage
// (port 0) and the UART program/data loader (port 1).
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   m0_req/we/addr/wdata     CPU request side
//   m0_gnt, m0_stall         CPU access issued / CPU pipeline freeze
//   m0_rdata, m0_rvalid      registered CPU read data and its 1-cycle strobe
//   m1_req/we/lock/addr/wdata loader request side (lock holds the bus)
//   m1_gnt                   loader access issued
//   m1_rdata, m1_rvalid      registered loader read data and strobe
//   ram_addr/wdata/wen       RAM drive (RAM writes on negedge)
//   ram_rdata                combinational RAM read data
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN : when defined, contended idle-state grants alternate
//                        between the ports instead of favouring the CPU.
// ---------------------------------------------------------------------------
module dram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_stall,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        IDLE,
        LOCK1
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

    state_t            r_state;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_m0Rvalid;
    logic              r_m1Rvalid;
    logic [DATA_W-1:0] r_m0Rdata;
    logic [DATA_W-1:0] r_m1Rdata;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_starved;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_rrPtr;
    logic              w_contended;
`endif

    assign w_starved = (r_waitCnt >= WAIT_W'(STARVE_LIMIT));

    // Grant selection. A held lock wins outright; otherwise the starvation
    // guard is checked first, then the contended case, then lone requests.
    // A lock-holding cycle that drops req or lock falls through to the
    // idle rules in the same cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_contended = 1'b0;
`endif
        if (!rst) begin
            if (r_state == LOCK1 && m1_req && m1_lock) begin
                w_gnt1 = 1'b1;
            end else if (m1_req && w_starved) begin
                w_gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                w_contended = 1'b1;
                if (r_rrPtr) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
`else
                w_gnt0 = 1'b1;
`endif
            end else if (m0_req) begin
                w_gnt0 = 1'b1;
            end else if (m1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // The RAM sees only the winner; with no grant everything is driven low
    // so a stray write can never occur.
    assign ram_wen   = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
    assign ram_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
    assign ram_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_stall  = m0_req & ~w_gnt0;
    assign m0_rdata  = r_m0Rdata;
    assign m1_rdata  = r_m1Rdata;
    assign m0_rvalid = r_m0Rvalid;
    assign m1_rvalid = r_m1Rvalid;

    // Lock state, loader wait counter, read-return registers and (when
    // enabled) the round-robin pointer. Read data is captured only on a
    // granted read so each port's rdata holds until its own next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_waitCnt  <= '0;
            r_m0Rvalid <= 1'b0;
            r_m1Rvalid <= 1'b0;
            r_m0Rdata  <= '0;
            r_m1Rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rrPtr    <= 1'b0;
`endif
        end else begin
            r_state <= (w_gnt1 && m1_lock) ? LOCK1 : IDLE;

            if (m1_req && !w_gnt1) begin
                r_waitCnt <= (r_waitCnt == WAIT_MAX) ? r_waitCnt
                                                     : r_waitCnt + WAIT_W'(1);
            end else begin
                r_waitCnt <= '0;
            end

            r_m0Rvalid <= w_gnt0 & ~m0_we;
            r_m1Rvalid <= w_gnt1 & ~m1_we;
            if (w_gnt0 && !m0_we) begin
                r_m0Rdata <= ram_rdata;
            end
            if (w_gnt1 && !m1_we) begin
                r_m1Rdata <= ram_rdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            // Point at whichever port lost the contended grant.
            if (w_contended) begin
                r_rrPtr <= w_gnt0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int WAIT_W       = 3;
    localparam int WAIT_MAX     = (1 << WAIT_W) - 1;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_stall, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic [31:0] ram_rdata;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] modelMem [int];
    bit          lockedM;
    int          waitM;
    bit          expRv0, expRv1;
    logic [31:0] expRd0, expRd1;
`ifdef ARB_ROUND_ROBIN_EN
    bit          ptrM;
`endif

    // Observations of the most recent cycle
    bit          lastG0, lastG1, lastWen, lastStall;
    bit          predG0, predG1;

    logic [31:0] ramMem [0:65535];

    dram_arbiter #(
        .ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .WAIT_W(WAIT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: writes on negedge, combinational read.
    assign ram_rdata = ramMem[ram_addr];
    initial begin
        for (int i = 0; i < 65536; i++) ramMem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (ram_wen) ramMem[ram_addr] = ram_wdata;
        end
    end

    function automatic logic [31:0] memRead(input int a);
        return modelMem.exists(a) ? modelMem[a] : 32'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Runs one clock cycle with the inputs currently driven: predicts the
    // winner from the arbitration rules, checks every output, then advances
    // the model past the rising edge.
    task automatic runCycle();
        bit          g0, g1, starved;
        bit          eWen;
        logic [15:0] eAddr;
        logic [31:0] eWdata;
`ifdef ARB_ROUND_ROBIN_EN
        bit          contended;
        contended = 0;
`endif
        #3;
        g0 = 0;
        g1 = 0;
        starved = (waitM >= STARVE_LIMIT);
        if (!rst) begin
            if (lockedM && m1_req && m1_lock)  g1 = 1;
            else if (m1_req && starved)        g1 = 1;
            else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                contended = 1;
                if (ptrM) g1 = 1; else g0 = 1;
`else
                g0 = 1;
`endif
            end
            else if (m0_req)                   g0 = 1;
            else if (m1_req)                   g1 = 1;
        end
        eWen   = (g0 && m0_we) || (g1 && m1_we);
        eAddr  = g0 ? m0_addr  : (g1 ? m1_addr  : 16'h0);
        eWdata = g0 ? m0_wdata : (g1 ? m1_wdata : 32'h0);

        checkOutput("m0_gnt",    m0_gnt,    g0);
        checkOutput("m1_gnt",    m1_gnt,    g1);
        checkOutput("m0_stall",  m0_stall,  m0_req && !g0);
        checkOutput("ram_wen",   ram_wen,   eWen);
        checkOutput("ram_addr",  ram_addr,  eAddr);
        checkOutput("ram_wdata", ram_wdata, eWdata);
        checkOutput("m0_rvalid", m0_rvalid, expRv0);
        checkOutput("m0_rdata",  m0_rdata,  expRd0);
        checkOutput("m1_rvalid", m1_rvalid, expRv1);
        checkOutput("m1_rdata",  m1_rdata,  expRd1);
        lastG0    = m0_gnt;
        lastG1    = m1_gnt;
        lastWen   = ram_wen;
        lastStall = m0_stall;
        predG0    = g0;
        predG1    = g1;

        @(posedge clk);
        #1;
        if (rst) begin
            lockedM = 0;
            waitM   = 0;
            expRv0  = 0;
            expRv1  = 0;
            expRd0  = 32'h0;
            expRd1  = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            ptrM    = 0;
`endif
        end else begin
            expRv0 = g0 && !m0_we;
            expRv1 = g1 && !m1_we;
            if (expRv0) expRd0 = memRead(int'(m0_addr));
            if (expRv1) expRd1 = memRead(int'(m1_addr));
            if (g0 && m0_we) modelMem[int'(m0_addr)] = m0_wdata;
            if (g1 && m1_we) modelMem[int'(m1_addr)] = m1_wdata;
            lockedM = g1 && m1_lock;
            if (m1_req && !g1) waitM = (waitM < WAIT_MAX) ? waitM + 1 : WAIT_MAX;
            else               waitM = 0;
`ifdef ARB_ROUND_ROBIN_EN
            if (contended) ptrM = !g0 ? 1'b0 : 1'b1;
`endif
        end
    endtask

    task automatic setM0(input bit req, input bit we, input logic [15:0] a,
                         input logic [31:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic setM1(input bit req, input bit we, input bit lk,
                         input logic [15:0] a, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
    endtask

    // Random traffic: a pending (ungranted) request is held unchanged,
    // otherwise a fresh request is drawn. Occasional resets are mixed in.
    task automatic applyStimulus();
        logic [15:0] hi;
        rst = ($urandom_range(0, 63) == 0);
        if (!(m0_req && !predG0)) begin
            hi = ($urandom_range(0, 3) == 0) ? 16'hA500 : 16'h0000;
            setM0($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                  hi | 16'($urandom_range(0, 15)), $urandom);
        end
        if (!(m1_req && !predG1)) begin
            hi = ($urandom_range(0, 3) == 0) ? 16'h5A00 : 16'h0000;
            setM1($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, hi | 16'($urandom_range(0, 15)), $urandom);
        end
    endtask

    // Directed scenarios first, then a randomized soak, all model-checked.
    initial begin
        logic [9:0] pattern;
        logic [9:0] expPattern;
        int         stalls;

        lockedM = 0; waitM = 0; expRv0 = 0; expRv1 = 0;
        expRd0 = 32'h0; expRd1 = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
        ptrM = 0;
`endif
        predG0 = 0; predG1 = 0;
        rst = 1'b1;
        setM0(1, 0, 16'h0001, 32'h0);
        setM1(1, 0, 0, 16'h0002, 32'h0);
        @(posedge clk);
        #1;

        // Requests present during reset must not be granted.
        runCycle();
        checkOutput("rst_no_gnt", {lastG0, lastG1}, 2'b00);
        runCycle();
        rst = 1'b0;
        setM0(0, 0, 16'h0, 32'h0);
        setM1(0, 0, 0, 16'h0, 32'h0);
        runCycle();

        // CPU read after a loader preload.
        setM1(1, 1, 0, 16'h0010, 32'h12345678);
        runCycle();
        setM1(0, 0, 0, 16'h0, 32'h0);
        setM0(1, 0, 16'h0010, 32'h0);
        runCycle();
        checkOutput("tp1_gnt", lastG0, 1'b1);
        checkOutput("tp1_stall", lastStall, 1'b0);
        checkOutput("tp1_rvalid", m0_rvalid, 1'b1);
        checkOutput("tp1_rdata", m0_rdata, 32'h12345678);
        setM0(0, 0, 16'h0, 32'h0);

        // Loader write then read back.
        setM1(1, 1, 0, 16'h0020, 32'hDEADBEEF);
        runCycle();
        checkOutput("tp2_wen_wr", lastWen, 1'b1);
        setM1(1, 0, 0, 16'h0020, 32'h0);
        runCycle();
        checkOutput("tp2_wen_rd", lastWen, 1'b0);
        checkOutput("tp2_rvalid", m1_rvalid, 1'b1);
        checkOutput("tp2_rdata", m1_rdata, 32'hDEADBEEF);
        setM1(0, 0, 0, 16'h0, 32'h0);
        runCycle();
        checkOutput("tp2_pulse_end", m1_rvalid, 1'b0);

        // Both ports requesting continuously.
        setM0(1, 0, 16'h0030, 32'h0);
        setM1(1, 0, 0, 16'h0031, 32'h0);
        pattern = '0;
        for (int i = 0; i < 10; i++) begin
            runCycle();
            pattern[i] = lastG1;
            checkOutput("tp3_one_gnt", {lastG0, lastG1} == 2'b01 || {lastG0, lastG1} == 2'b10, 1'b1);
        end
`ifdef ARB_ROUND_ROBIN_EN
        expPattern = 10'b1010101010;
`else
        expPattern = 10'b1000010000;
`endif
        checkOutput("tp3_pattern", pattern, expPattern);
        setM0(0, 0, 16'h0, 32'h0);
        setM1(0, 0, 0, 16'h0, 32'h0);
        runCycle();

        // Locked loader burst holds off the CPU.
        setM1(1, 1, 1, 16'h0100, $urandom);
        runCycle();
        stalls = 0;
        setM0(1, 0, 16'h0010, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            setM1(1, 1, 1, 16'h0100 + 16'(i), $urandom);
            runCycle();
            if (lastStall) stalls++;
        end
        checkOutput("tp4_stalls", stalls, 8);
        setM1(0, 0, 0, 16'h0, 32'h0);
        runCycle();
        checkOutput("tp4_release", lastG0, 1'b1);
        setM0(0, 0, 16'h0, 32'h0);
        runCycle();

        // Reset in the middle of a locked burst.
        setM1(1, 1, 1, 16'h0200, $urandom);
        runCycle();
        setM0(1, 0, 16'h0011, 32'h0);
        setM1(1, 1, 1, 16'h0201, $urandom);
        runCycle();
        rst = 1'b1;
        setM1(1, 0, 1, 16'h0200, 32'h0);
        runCycle();
        checkOutput("tp5_no_gnt", {lastG0, lastG1}, 2'b00);
        checkOutput("tp5_no_wen", lastWen, 1'b0);
        checkOutput("tp5_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        rst = 1'b0;
        runCycle();
        checkOutput("tp5_m0_after", lastG0, 1'b1);
        setM0(0, 0, 16'h0, 32'h0);
        runCycle();
        setM1(0, 0, 0, 16'h0, 32'h0);
        runCycle();

        // Randomized soak.
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
